red_pitaya_sys_initiator: RTL and testbench
===========================================

Name: red_pitaya_sys_initiator

Overview:
Single-outstanding system-bus initiator. It is the bus-master end of the same sys_addr/sys_wdata/sys_wen/sys_ren/sys_rdata/sys_err/sys_ack interface that the PID and other peripheral register banks implement as responders. It takes write and read commands over a valid/ready port, drives one strobe transaction, and waits for ack, err or timeout. The result is returned over a valid/ready response port. Typical uses are autonomous PID gain/setpoint loaders and register sequencers inside the FPGA.

Parameters:
AW, 32, bus address width
DW, 32, bus data width
TIMEOUT, 255, WAIT-state cycles without ack/err before the transaction is abandoned; legal range 1..65535

Ports:
clk_i  in  1  processing clock
rstn_i  in  1  reset; asynchronous, active low
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when high together with cmd_valid_i
cmd_we_i  in  1  1 = write, 0 = read
cmd_addr_i  in  AW  target address
cmd_wdata_i  in  DW  write data; ignored for reads
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed
rsp_rdata_o  out  DW  captured sys_rdata; 0 for writes and timeouts
rsp_err_o  out  1  responder signalled sys_err
rsp_timeout_o  out  1  no ack/err within TIMEOUT cycles
busy_o  out  1  high in any state other than IDLE
sys_addr  out  AW  bus address
sys_wdata  out  DW  bus write data
sys_wen  out  1  write strobe
sys_ren  out  1  read strobe
sys_rdata  in  DW  bus read data
sys_err  in  1  bus error
sys_ack  in  1  bus acknowledge

Behaviour:
- Reset (async assert, release synchronous to clk_i): state IDLE. All outputs 0 except cmd_ready_o, which is 1. Timeout counter 0. Reset mid-transaction abandons it silently; no response is produced.
- FSM states: IDLE, STRB, WAIT, RESP.
- IDLE: cmd_ready_o=1. A handshake at edge k registers addr/wdata/we into sys_addr/sys_wdata and enters STRB.
- STRB (cycle after edge k): exactly one of sys_wen or sys_ren is high, for exactly one cycle. sys_ack/sys_err in this cycle are ignored as stale. Next state is WAIT with counter cleared.
- WAIT: strobes are low, and sys_addr/sys_wdata are held stable.
  - sys_ack or sys_err sampled high: capture the result and go to RESP.
  - rsp_err_o = sys_err.
  - rsp_rdata_o = sys_rdata for a read when sys_ack is high (error takes priority for flagging only), otherwise 0.
  - Counter increments each WAIT cycle. If it reaches TIMEOUT with no ack/err: go to RESP with rsp_timeout_o=1, rsp_err_o=0, rsp_rdata_o=0.
  - If ack arrives in the same cycle the counter reaches TIMEOUT, the ack wins and the timeout flag stays 0.
- Latency: against a responder that acks one cycle after the strobe, the ack is sampled at edge k+2 and rsp_valid_o is high from cycle k+3. Minimum transaction period is 4 cycles.
- RESP: rsp_valid_o=1. rsp_* stay stable until rsp_valid_o && rsp_ready_i, then return to IDLE. rsp_valid_o never drops without a handshake.
- sys_addr/sys_wdata retain their last values in IDLE; no zeroing between transactions.
- busy_o = (state != IDLE).
- sys_ack/sys_err outside WAIT are ignored, with no state change.

Optional Feature:
Macro RP_SYS_INIT_STATS_EN.
- Defined: adds outputs stat_tx_o[16], stat_err_o[16] and stat_to_o[16]. These are saturating counters (hold at 0xFFFF) of completed transactions, sys_err responses, and timeouts. Each increments on entry to RESP. Async reset clears them to 0.
- Not defined: these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Write with 1-cycle-ack responder: cmd we=1, addr=0x24, wdata=0x1ABC.
  - Required: sys_wen high for exactly 1 cycle with sys_addr=0x24 and sys_wdata=0x1ABC, sys_ren low.
  - Required: rsp_valid_o 3 cycles after the handshake, with err=0, timeout=0, rdata=0.
- Read, responder returns 0x0000_1ABC with ack: rsp_rdata_o=0x1ABC, rsp_err_o=0; sys_ren pulses exactly once.
- Responder asserts sys_err and sys_ack together on a read: rsp_err_o=1, rsp_timeout_o=0.
- TIMEOUT=8 and responder never acks: rsp_timeout_o=1, rsp_rdata_o=0, with rsp_valid_o rising after the 8th WAIT cycle. A stale ack held during STRB is ignored. Ack on the 8th WAIT cycle gives timeout=0.
- rsp_ready_i held low 5 cycles: rsp_* stable throughout, cmd_ready_o=0, a new cmd_valid_i is not accepted; the handshake on cycle 6 returns to IDLE.
- rstn_i asserted during WAIT: all outputs go to 0 immediately with cmd_ready_o=1 and no response. With RP_SYS_INIT_STATS_EN defined, the counters read 0 after reset and stat_tx_o=1 after one complete write.

Source files
------------

// File: rtl/red_pitaya_sys_initiator.sv
// Single-outstanding system-bus initiator: one strobe per command, waits for ack/err/timeout.
// Optional macro RP_SYS_INIT_STATS_EN adds saturating transaction/error/timeout counters.
module red_pitaya_sys_initiator #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_we_i,
  input  logic [AW-1:0] cmd_addr_i,
  input  logic [DW-1:0] cmd_wdata_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [DW-1:0] rsp_rdata_o,
  output logic          rsp_err_o,
  output logic          rsp_timeout_o,
  output logic          busy_o,
`ifdef RP_SYS_INIT_STATS_EN
  output logic [15:0]   stat_tx_o,
  output logic [15:0]   stat_err_o,
  output logic [15:0]   stat_to_o,
`endif
  output logic [AW-1:0] sys_addr,
  output logic [DW-1:0] sys_wdata,
  output logic          sys_wen,
  output logic          sys_ren,
  input  logic [DW-1:0] sys_rdata,
  input  logic          sys_err,
  input  logic          sys_ack
);

  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {IDLE, STRB, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            we_q, we_d;
  logic            wen_q, wen_d;
  logic            ren_q, ren_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic            rsp_to_q, rsp_to_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            busy_q, busy_d;
  logic            enter_resp;

  // Next-state, bus strobes and response capture
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    wen_d       = 1'b0;
    ren_d       = 1'b0;
    cnt_d       = cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_to_d    = rsp_to_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          addr_d  = cmd_addr_i;
          wdata_d = cmd_wdata_i;
          we_d    = cmd_we_i;
          wen_d   = cmd_we_i;
          ren_d   = !cmd_we_i;
          state_d = STRB;
        end
      end
      STRB: begin
        // Ack/err seen here belongs to an earlier transaction
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (sys_ack || sys_err) begin
          state_d     = RESP;
          rsp_err_d   = sys_err;
          rsp_to_d    = 1'b0;
          rsp_rdata_d = (!we_q && sys_ack) ? sys_rdata : '0;
        end else if (cnt_d == CW'(TIMEOUT)) begin
          state_d     = RESP;
          rsp_err_d   = 1'b0;
          rsp_to_d    = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
    endcase
    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    rsp_valid_d = (state_d == RESP);
    enter_resp  = (state_q == WAIT) && (state_d == RESP);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      cnt_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      wen_q       <= wen_d;
      ren_q       <= ren_d;
      cnt_q       <= cnt_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_to_q    <= rsp_to_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
    end
  end

`ifdef RP_SYS_INIT_STATS_EN
  logic [15:0] stat_tx_q, stat_tx_d;
  logic [15:0] stat_err_q, stat_err_d;
  logic [15:0] stat_to_q, stat_to_d;

  // Saturating counters, bumped once per response
  always_comb begin
    stat_tx_d  = stat_tx_q;
    stat_err_d = stat_err_q;
    stat_to_d  = stat_to_q;
    if (enter_resp) begin
      if (stat_tx_q != 16'hFFFF) stat_tx_d = stat_tx_q + 16'd1;
      if (rsp_err_d && stat_err_q != 16'hFFFF) stat_err_d = stat_err_q + 16'd1;
      if (rsp_to_d && stat_to_q != 16'hFFFF) stat_to_d = stat_to_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      stat_tx_q  <= '0;
      stat_err_q <= '0;
      stat_to_q  <= '0;
    end else begin
      stat_tx_q  <= stat_tx_d;
      stat_err_q <= stat_err_d;
      stat_to_q  <= stat_to_d;
    end
  end

  assign stat_tx_o  = stat_tx_q;
  assign stat_err_o = stat_err_q;
  assign stat_to_o  = stat_to_q;
`else
  logic unused_enter_resp;
  assign unused_enter_resp = enter_resp;
`endif

  assign cmd_ready_o   = cmd_ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_to_q;
  assign busy_o        = busy_q;
  assign sys_addr      = addr_q;
  assign sys_wdata     = wdata_q;
  assign sys_wen       = wen_q;
  assign sys_ren       = ren_q;

endmodule

// File: tb/tb_red_pitaya_sys_initiator.sv
// Bench for red_pitaya_sys_initiator: scripted responder, scoreboard of expected responses.
module tb_red_pitaya_sys_initiator;
  localparam int unsigned TO = 8;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [31:0] cmd_addr_i, cmd_wdata_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o, rsp_timeout_o, busy_o;
  logic [31:0] sys_addr, sys_wdata, sys_rdata;
  logic        sys_wen, sys_ren, sys_err, sys_ack;
`ifdef RP_SYS_INIT_STATS_EN
  logic [15:0] stat_tx_o, stat_err_o, stat_to_o;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  red_pitaya_sys_initiator #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o), .busy_o(busy_o),
`ifdef RP_SYS_INIT_STATS_EN
    .stat_tx_o(stat_tx_o), .stat_err_o(stat_err_o), .stat_to_o(stat_to_o),
`endif
    .sys_addr(sys_addr), .sys_wdata(sys_wdata), .sys_wen(sys_wen), .sys_ren(sys_ren),
    .sys_rdata(sys_rdata), .sys_err(sys_err), .sys_ack(sys_ack)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Command, scripted responder and response checks for one transaction
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int ack_at, input logic err, input logic [31:0] rdata,
                        input logic stale, input int hold);
    exp_t e;
    int   waits;
    logic got;
    @(negedge clk_i);
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = addr; cmd_wdata_i = wdata;
    n_checks++;
    if (cmd_ready_o !== 1'b1) $display("FAIL cmd_ready_idle: got %b need 1", cmd_ready_o);
    else n_pass++;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    e.to    = (ack_at == 0) || (ack_at > int'(TO));
    e.err   = !e.to && err;
    e.rdata = (!e.to && !we) ? rdata : 32'h0;
    e.lat   = e.to ? int'(TO) : ack_at;
    sb.push_back(e);
    // STRB cycle: exactly one strobe, address/data registered
    n_checks++;
    if ({sys_wen, sys_ren, sys_addr, sys_wdata, rsp_valid_o, busy_o} !== {we, !we, addr, wdata, 1'b0, 1'b1})
      $display("FAIL strobe: wen=%b ren=%b addr=%h wdata=%h valid=%b busy=%b need wen=%b ren=%b addr=%h wdata=%h",
               sys_wen, sys_ren, sys_addr, sys_wdata, rsp_valid_o, busy_o, we, !we, addr, wdata);
    else n_pass++;
    if (stale) begin sys_ack = 1'b1; sys_err = err; sys_rdata = 32'hDEAD_BEEF; end
    @(negedge clk_i);
    sys_ack = 1'b0; sys_err = 1'b0;
    waits = 0;
    got   = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      n_checks++;
      if ({sys_wen, sys_ren, sys_addr, sys_wdata, rsp_valid_o} !== {2'b00, addr, wdata, 1'b0})
        $display("FAIL wait_hold: cycle %0d wen=%b ren=%b addr=%h wdata=%h valid=%b", i,
                 sys_wen, sys_ren, sys_addr, sys_wdata, rsp_valid_o);
      else n_pass++;
      sys_ack   = (i == ack_at);
      sys_err   = err && (i == ack_at);
      sys_rdata = rdata;
      @(negedge clk_i);
      sys_ack = 1'b0; sys_err = 1'b0;
      waits = i;
      if (rsp_valid_o) begin got = 1'b1; break; end
    end
    n_checks++;
    if (!got || waits != sb[0].lat)
      $display("FAIL rsp_latency: valid after %0d wait cycles (seen=%b) need %0d", waits, got, sb[0].lat);
    else n_pass++;
    if (!got) begin void'(sb.pop_front()); return; end
    e = sb.pop_front();
    // Back-pressure: response stable, new command refused
    for (int h = 0; h < hold; h++) begin
      cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_addr_i = 32'h0BAD; cmd_wdata_i = 32'h0BAD;
      n_checks++;
      if ({rsp_valid_o, cmd_ready_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o} !== {2'b10, e.rdata, e.err, e.to})
        $display("FAIL rsp_hold: cycle %0d valid=%b ready=%b rdata=%h err=%b to=%b need rdata=%h err=%b to=%b",
                 h, rsp_valid_o, cmd_ready_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o, e.rdata, e.err, e.to);
      else n_pass++;
      @(negedge clk_i);
    end
    cmd_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    n_checks++;
    if ({rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o} !== {1'b1, e.rdata, e.err, e.to})
      $display("FAIL rsp_data: valid=%b rdata=%h err=%b to=%b need rdata=%h err=%b to=%b",
               rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o, e.rdata, e.err, e.to);
    else n_pass++;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    n_checks++;
    if ({rsp_valid_o, busy_o, cmd_ready_o} !== 3'b001)
      $display("FAIL back_idle: valid=%b busy=%b ready=%b need 0 0 1", rsp_valid_o, busy_o, cmd_ready_o);
    else n_pass++;
  endtask

  task automatic test_reset;
    rstn_i = 1'b0;
    #12;
    n_checks++;
    if ({cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o, busy_o, sys_addr, sys_wdata, sys_wen, sys_ren}
        !== {1'b1, 1'b0, 32'h0, 3'b000, 64'h0, 2'b00})
      $display("FAIL reset_state: ready=%b valid=%b rdata=%h busy=%b addr=%h wdata=%h wen=%b ren=%b",
               cmd_ready_o, rsp_valid_o, rsp_rdata_o, busy_o, sys_addr, sys_wdata, sys_wen, sys_ren);
    else n_pass++;
    @(negedge clk_i);
    rstn_i = 1'b1;
  endtask

  task automatic test_write;
    do_txn(1'b1, 32'h24, 32'h1ABC, 1, 1'b0, 32'h5555_AAAA, 1'b0, 0);
  endtask

  task automatic test_read;
    do_txn(1'b0, 32'h28, 32'h0, 1, 1'b0, 32'h0000_1ABC, 1'b0, 0);
  endtask

  task automatic test_err;
    do_txn(1'b0, 32'h2C, 32'h0, 2, 1'b1, 32'h1234_5678, 1'b0, 0);
  endtask

  task automatic test_timeout;
    do_txn(1'b0, 32'h30, 32'h0, 0, 1'b0, 32'h7777, 1'b1, 0);
    do_txn(1'b0, 32'h34, 32'h0, int'(TO), 1'b0, 32'h00C0_FFEE, 1'b1, 0);
  endtask

  task automatic test_backpressure;
    do_txn(1'b1, 32'h40, 32'hA5A5, 1, 1'b0, 32'h0, 1'b0, 5);
  endtask

  task automatic test_back_to_back;
    do_txn(1'b0, 32'h50, 32'h0, 1, 1'b0, 32'h1111_2222, 1'b0, 0);
    do_txn(1'b1, 32'h54, 32'h3333, 3, 1'b0, 32'h0, 1'b0, 0);
  endtask

  task automatic test_reset_mid;
    @(negedge clk_i);
    cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_i = 32'h60; cmd_wdata_i = 32'h99;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    @(negedge clk_i);
    #2 rstn_i = 1'b0;
    #1;
    n_checks++;
    if ({cmd_ready_o, rsp_valid_o, busy_o, sys_addr, sys_wdata, sys_wen, sys_ren} !== {3'b100, 64'h0, 2'b00})
      $display("FAIL reset_mid: ready=%b valid=%b busy=%b addr=%h wen=%b ren=%b",
               cmd_ready_o, rsp_valid_o, busy_o, sys_addr, sys_wen, sys_ren);
    else n_pass++;
    @(negedge clk_i);
    rstn_i = 1'b1;
    sys_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      n_checks++;
      if ({rsp_valid_o, busy_o, cmd_ready_o} !== 3'b001)
        $display("FAIL reset_no_rsp: cycle %0d valid=%b busy=%b ready=%b", i, rsp_valid_o, busy_o, cmd_ready_o);
      else n_pass++;
    end
    sys_ack = 1'b0;
  endtask

`ifdef RP_SYS_INIT_STATS_EN
  task automatic test_stats;
    n_checks++;
    if ({stat_tx_o, stat_err_o, stat_to_o} !== 48'h0)
      $display("FAIL stats_reset: tx=%0d err=%0d to=%0d need 0", stat_tx_o, stat_err_o, stat_to_o);
    else n_pass++;
    do_txn(1'b1, 32'h70, 32'h1, 1, 1'b0, 32'h0, 1'b0, 0);
    n_checks++;
    if ({stat_tx_o, stat_err_o, stat_to_o} !== {16'd1, 16'd0, 16'd0})
      $display("FAIL stats_write: tx=%0d err=%0d to=%0d need 1 0 0", stat_tx_o, stat_err_o, stat_to_o);
    else n_pass++;
  endtask
`endif

  initial begin
    cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_addr_i = '0; cmd_wdata_i = '0;
    rsp_ready_i = 1'b0; sys_rdata = '0; sys_err = 1'b0; sys_ack = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_err();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef RP_SYS_INIT_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
